// File: rtl/button_pkg.sv
// Shared types and default timing for the push-button conditioning path.
// Timing defaults assume a 100 MHz system clock.
package button_pkg;

    typedef enum logic [5:0] {
        ST_IDLE         = 6'b000001,
        ST_WAIT_PRESS   = 6'b000010,
        ST_PRESS_PULSE  = 6'b000100,
        ST_HOLD         = 6'b001000,
        ST_REPEAT_PULSE = 6'b010000,
        ST_WAIT_RELEASE = 6'b100000
    } btn_state_e;

    localparam int DEF_N_BTN         = 32'd4;
    localparam int DEF_DEBOUNCE_CNT  = 32'd500000;
    localparam int DEF_REPEAT_DELAY  = 32'd50000000;
    localparam int DEF_REPEAT_PERIOD = 32'd10000000;

    function automatic int max3(input int a, input int b, input int c);
        int m;
        m = a;
        if (b > m) begin
            m = b;
        end else begin
            m = m;
        end
        if (c > m) begin
            m = c;
        end else begin
            m = m;
        end
        return m;
    endfunction

    // Counter only ever reaches limit-1, so $clog2(limit) bits suffice.
    function automatic int cnt_width(input int lim);
        return (lim > 32'd1) ? $clog2(lim) : 32'd1;
    endfunction

endpackage

// File: rtl/debounce_channel.sv
// One button channel: two-flop synchronizer, shared debounce/repeat counter,
// and a Moore FSM producing the debounced level plus press/repeat pulses.
module debounce_channel
    import button_pkg::*;
#(
    parameter int DEBOUNCE_CNT  = DEF_DEBOUNCE_CNT,
    parameter int REPEAT_DELAY  = DEF_REPEAT_DELAY,
    parameter int REPEAT_PERIOD = DEF_REPEAT_PERIOD
) (
    input  logic clk,
    input  logic reset,
    input  logic btn_in,
    output logic dpb,
    output logic scen,
    output logic mcen
);

    localparam int CW = cnt_width(max3(DEBOUNCE_CNT, REPEAT_DELAY, REPEAT_PERIOD));
    localparam logic [CW-1:0] CNT_ZERO   = CW'(32'd0);
    localparam logic [CW-1:0] CNT_ONE    = CW'(32'd1);
    localparam logic [CW-1:0] DB_LAST    = CW'(DEBOUNCE_CNT - 32'd1);
    localparam logic [CW-1:0] DELAY_LAST = CW'(REPEAT_DELAY - 32'd1);
    localparam logic [CW-1:0] PER_LAST   = CW'(REPEAT_PERIOD - 32'd1);

    btn_state_e    state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [CW-1:0] hold_last_s;
    logic          rep_q, rep_d;
    logic          s1_q, s1_d, s2_q, s2_d;
    logic          dpb_q, dpb_d, scen_q, scen_d, mcen_q, mcen_d;
    logic          sync_s;

    assign sync_s = s2_q;

    // Next-state, counter and output decode; outputs follow the next state so they register with it.
    always_comb begin
        s1_d    = btn_in;
        s2_d    = s1_q;
        state_d = state_q;
        cnt_d   = cnt_q;
        rep_d   = rep_q;

        if (rep_q) begin
            hold_last_s = PER_LAST;
        end else begin
            hold_last_s = DELAY_LAST;
        end

        case (state_q)
            ST_IDLE: begin
                cnt_d = CNT_ZERO;
                if (sync_s) begin
                    state_d = ST_WAIT_PRESS;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_WAIT_PRESS: begin
                if (!sync_s) begin
                    state_d = ST_IDLE;
                    cnt_d   = CNT_ZERO;
                end else if (cnt_q == DB_LAST) begin
                    state_d = ST_PRESS_PULSE;
                    cnt_d   = CNT_ZERO;
                end else begin
                    cnt_d   = cnt_q + CNT_ONE;
                end
            end
            ST_PRESS_PULSE: begin
                state_d = ST_HOLD;
                cnt_d   = CNT_ZERO;
                rep_d   = 1'b0;
            end
            ST_HOLD: begin
                if (!sync_s) begin
                    state_d = ST_WAIT_RELEASE;
                    cnt_d   = CNT_ZERO;
                end else if (cnt_q == hold_last_s) begin
                    state_d = ST_REPEAT_PULSE;
                    cnt_d   = CNT_ZERO;
                end else begin
                    cnt_d   = cnt_q + CNT_ONE;
                end
            end
            ST_REPEAT_PULSE: begin
                state_d = ST_HOLD;
                cnt_d   = CNT_ZERO;
                rep_d   = 1'b1;
            end
            ST_WAIT_RELEASE: begin
                // A bounce back high resumes the hold; the repeat cadence restarts.
                if (sync_s) begin
                    state_d = ST_HOLD;
                    cnt_d   = CNT_ZERO;
                end else if (cnt_q == DB_LAST) begin
                    state_d = ST_IDLE;
                    cnt_d   = CNT_ZERO;
                end else begin
                    cnt_d   = cnt_q + CNT_ONE;
                end
            end
            default: begin
                state_d = ST_IDLE;
                cnt_d   = CNT_ZERO;
                rep_d   = 1'b0;
            end
        endcase

        dpb_d  = (state_d != ST_IDLE) && (state_d != ST_WAIT_PRESS);
        scen_d = (state_d == ST_PRESS_PULSE);
        mcen_d = (state_d == ST_REPEAT_PULSE);
    end

    // Synchronizer, FSM state, counter, repeat flag and registered outputs.
    always_ff @(posedge clk) begin
        if (reset) begin
            s1_q    <= 1'b0;
            s2_q    <= 1'b0;
            state_q <= ST_IDLE;
            cnt_q   <= CNT_ZERO;
            rep_q   <= 1'b0;
            dpb_q   <= 1'b0;
            scen_q  <= 1'b0;
            mcen_q  <= 1'b0;
        end else begin
            s1_q    <= s1_d;
            s2_q    <= s2_d;
            state_q <= state_d;
            cnt_q   <= cnt_d;
            rep_q   <= rep_d;
            dpb_q   <= dpb_d;
            scen_q  <= scen_d;
            mcen_q  <= mcen_d;
        end
    end

    assign dpb  = dpb_q;
    assign scen = scen_q;
    assign mcen = mcen_q;

endmodule

// File: rtl/button_conditioner.sv
// Conditions N_BTN raw push-buttons into debounced levels, single-press
// enables and auto-repeat enables for the game logic.
module button_conditioner
    import button_pkg::*;
#(
    parameter int N_BTN         = DEF_N_BTN,
    parameter int DEBOUNCE_CNT  = DEF_DEBOUNCE_CNT,
    parameter int REPEAT_DELAY  = DEF_REPEAT_DELAY,
    parameter int REPEAT_PERIOD = DEF_REPEAT_PERIOD
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [N_BTN-1:0] btn_in,
    output logic [N_BTN-1:0] DPBs,
    output logic [N_BTN-1:0] SCENs,
    output logic [N_BTN-1:0] MCENs
);

    for (genvar g = 0; g < N_BTN; g++) begin : g_ch
        debounce_channel #(
            .DEBOUNCE_CNT (DEBOUNCE_CNT),
            .REPEAT_DELAY (REPEAT_DELAY),
            .REPEAT_PERIOD(REPEAT_PERIOD)
        ) u_ch (
            .clk   (clk),
            .reset (reset),
            .btn_in(btn_in[g]),
            .dpb   (DPBs[g]),
            .scen  (SCENs[g]),
            .mcen  (MCENs[g])
        );
    end

endmodule
